// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider.
//   state_t   : FSM state encoding (IDLE/CALC/DONE, 2 bits)
//   cnt_width : width of the step counter for an n-bit divider, clog2(n+1)
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Start/done handshake and operand/result bus of the restoring divider.
//   master : drives start, x (dividend), y (divisor); observes results
//   slave  : the divider; drives busy, done, q, r, div_by_zero, over_flow
interface restoring_divider_if #(
  parameter int n = 4
);
  logic         start;
  logic [n-1:0] x;
  logic [n-1:0] y;
  logic         busy;
  logic         done;
  logic [n-1:0] q;
  logic [n-1:0] r;
  logic         div_by_zero;
  logic         over_flow;

  modport master (
    output start, x, y,
    input  busy, done, q, r, div_by_zero, over_flow
  );

  modport slave (
    input  start, x, y,
    output busy, done, q, r, div_by_zero, over_flow
  );
endinterface

// File: rtl/restoring_divider_div_step.sv
// One combinational iteration of the restoring division.
//   r_in/q_in : partial remainder and working quotient before the step
//   d         : divisor magnitude
//   r_out/q_out : values after shift, trial subtract and restore
// The partial remainder is carried as n bits: after a step it is always
// below the divisor. The shifted value is n+1 bits; its top bit and the
// carry-out of the n-bit subtractor together say whether it reached d.
module div_step #(
  parameter int n = 4
) (
  input  logic [n-1:0] r_in,
  input  logic [n-1:0] q_in,
  input  logic [n-1:0] d,
  output logic [n-1:0] r_out,
  output logic [n-1:0] q_out
);
  logic [n:0]   r_sh;
  logic [n-1:0] t;
  logic         cout;
  logic         accept;
  logic         sub;

  assign sub  = 1'b1;
  assign r_sh = {r_in, q_in[n-1]};

  // Adder/subtractor: a + (b ^ {n{sub}}) + sub; carry-out means no borrow.
  assign {cout, t} = {1'b0, r_sh[n-1:0]} + {1'b0, d ^ {n{sub}}} + {{n{1'b0}}, sub};

  // A set top bit already means the shifted remainder exceeds any n-bit divisor.
  assign accept = r_sh[n] | cout;
  assign r_out  = accept ? t : r_sh[n-1:0];
  assign q_out  = {q_in[n-2:0], accept};
endmodule

// File: rtl/restoring_divider.sv
// Sequential n-bit restoring divider, one quotient bit per clock.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : restoring_divider_if.slave (start/x/y in; busy/done/q/r/
//              div_by_zero/over_flow out)
// Latency: start accepted in cycle 0, done pulses in cycle n+1.
// Optional feature: define RESTORING_DIVIDER_SIGNED_EN for two's complement
// operands (magnitude iteration with sign fix-up and overflow detection).
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int n = 4
) (
  input  logic clk,
  input  logic rst,
  restoring_divider_if.slave bus
);
  localparam int CW = cnt_width(n);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [n-1:0]  rem_p;
  logic [n-1:0]  quo_p;
  logic [n-1:0]  dvs_p;
  logic          dz_pend;
  logic [n-1:0]  rem_nxt;
  logic [n-1:0]  quo_nxt;
  logic [n-1:0]  x_mag;
  logic [n-1:0]  y_mag;
  logic [n-1:0]  q_fin;
  logic [n-1:0]  r_fin;
  logic          accept;

  assign accept = (state == IDLE) && bus.start;

`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic ov_pend;

  function automatic logic [n-1:0] mag(input logic signed [n-1:0] v);
    // The most negative value maps onto 2^(n-1), which is exact as unsigned.
    return v[n-1] ? -v : v;
  endfunction

  function automatic logic [n-1:0] cond_neg(input logic [n-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign x_mag = mag(bus.x);
  assign y_mag = mag(bus.y);
  assign q_fin = dz_pend ? '1 : cond_neg(quo_nxt, neg_q);
  assign r_fin = cond_neg(rem_nxt, neg_r);

  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q <= bus.x[n-1] ^ bus.y[n-1];
      neg_r <= bus.x[n-1];
    end
  end
`else
  assign x_mag         = bus.x;
  assign y_mag         = bus.y;
  assign q_fin         = quo_nxt;
  assign r_fin         = rem_nxt;
  assign bus.over_flow = 1'b0;
`endif

  div_step #(.n(n)) u_step (
    .r_in  (rem_p),
    .q_in  (quo_p),
    .d     (dvs_p),
    .r_out (rem_nxt),
    .q_out (quo_nxt)
  );

  // Operand / iteration registers: loaded on acceptance, stepped in CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_p <= '0;
      quo_p <= x_mag;
      dvs_p <= y_mag;
    end else if (state == CALC) begin
      rem_p <= rem_nxt;
      quo_p <= quo_nxt;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      dz_pend         <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.q           <= '0;
      bus.r           <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      ov_pend         <= 1'b0;
      bus.over_flow   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state    <= CALC;
            cnt      <= '0;
            bus.busy <= 1'b1;
            dz_pend  <= (bus.y == '0);
`ifdef RESTORING_DIVIDER_SIGNED_EN
            ov_pend  <= (bus.x == {1'b1, {(n-1){1'b0}}}) && (bus.y == '1);
`endif
          end
        end
        CALC: begin
          if (cnt == CW'(n - 1)) begin
            // Last step: results are taken straight from the step outputs.
            state           <= DONE;
            bus.done        <= 1'b1;
            bus.q           <= q_fin;
            bus.r           <= r_fin;
            bus.div_by_zero <= dz_pend;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            bus.over_flow   <= ov_pend;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
